ram_arbiter: RTL
================

Name: ram_arbiter

Overview:
- Two-requester controller that shares the 16x8 scratch RAM (combinational read; write captured on the rising edge of its write-enable strobe).
- Serialises read and write transactions from requester 0 and requester 1 with round-robin priority.
- Generates a glitch-free setup/strobe/hold write sequence and registers read data back to the owning requester.
- Sits between the datapath/loader masters and the RAM instance.

Parameters:
- AW, 4, RAM address width.
- DW, 8, RAM data width.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- req  input  2  per-requester transaction request, bit i = requester i
- we  input  2  per-requester type: 1 = write, 0 = read; valid while req[i] high
- addr  input  2*AW  requester i address in bits [i*AW +: AW]
- wdata  input  2*DW  requester i write data in bits [i*DW +: DW]
- ack  output  2  one-cycle completion pulse, bit i = requester i
- rdata  output  2*DW  requester i registered read data in bits [i*DW +: DW]
- busy  output  1  high whenever the FSM is not IDLE
- owner  output  1  index of the requester currently granted; valid while busy
- ram_addr_read  output  AW  RAM read address
- ram_read_enable  output  1  RAM read enable
- ram_data_out  input  DW  RAM read data (combinational from RAM)
- ram_data_in  output  DW  RAM write data
- ram_addr_write  output  AW  RAM write address
- ram_write_enable  output  1  RAM write strobe; the RAM writes on its rising edge

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous and active-high.
- Reset values:
  - state = IDLE.
  - ack = 0, rdata = 0, busy = 0, owner = 0.
  - All ram_* outputs = 0.
  - last_grant = 1, so requester 0 wins the first contention.
  - ram_write_enable must fall immediately on rst assertion, not at the next clock edge.
- All outputs are registered. ram_read_enable, ram_write_enable, ack and busy are decoded from registered state only.
- FSM states: IDLE, RD, WSETUP, WSTROBE, WHOLD, ACK.
- IDLE:
  - If exactly one req bit is high, grant that requester.
  - If both are high, grant the requester != last_grant.
  - On grant: owner <= i, last_grant <= i, and latch addr/wdata/we of the winner into ram_addr_read/ram_addr_write/ram_data_in.
  - Next state is RD if we[i]=0, else WSETUP.
  - No req: stay in IDLE; ram_* outputs hold their last values.
- RD (1 cycle):
  - ram_read_enable = 1.
  - At the end of the cycle, capture ram_data_out into rdata[owner]. The rdata slice of the other requester is unchanged.
  - Next state: ACK.
- WSETUP (1 cycle): address and data are stable, ram_write_enable = 0. Next state: WSTROBE.
- WSTROBE (1 cycle): ram_write_enable = 1; the rising edge commits the write. Next state: WHOLD.
- WHOLD (1 cycle): ram_write_enable = 0; address and data are still held. Next state: ACK.
- ACK (1 cycle):
  - ack[owner] = 1; req is ignored in this state.
  - Next state: IDLE, where req is sampled again.
- Latency, from the grant edge (the IDLE cycle that sees req):
  - Read: ack high 2 cycles later.
  - Write: ack high 4 cycles later.
  - Write strobe: exactly one high cycle per write; never two consecutive high cycles.
- Requester protocol:
  - Hold req, we, addr and wdata stable from assertion until ack is seen.
  - Drop req (or present a new transaction) at the edge ending the ack cycle.
  - req still high in the following IDLE cycle is treated as a new transaction.
- Fairness: under continuous contention the grants alternate 0,1,0,1,...
- Boundary conditions:
  - Inputs changing mid-transaction are ignored, because they were latched at grant.
  - The non-owner's req stays pending and is not lost.
  - Reset mid-transaction:
    - Abort to IDLE; no ack is issued.
    - A write aborted before WSTROBE leaves the RAM unchanged.
    - A write aborted in WSTROBE/WHOLD has already committed.
- Width rule: rdata updates only on a read; writes never modify rdata.

Test Plan:
- Requester 0 writes addr 3 = 0xA5, then reads addr 3:
  - ack[0] at grant+4 for the write and at grant+2 for the read.
  - rdata[1:0 slice... i.e. rdata[7:0] = 0xA5; rdata[15:8] stays 0.
- Both req high from reset, both writing (r0 addr 1 = 0x11, r1 addr 2 = 0x22):
  - r0 is served first, then r1.
  - Reading back gives 0x11 and 0x22.
  - The owner sequence is 0, then 1.
- Both requesters issue continuous reads for 8 transactions:
  - acks alternate 0,1,0,1,...
  - Each requester gets exactly 4 acks.
- Write pulse check: monitor ram_write_enable during a write of 0x3C to addr 15.
  - Exactly one high cycle.
  - ram_addr_write = 15 and ram_data_in = 0x3C are stable for the cycle before, during and after the strobe.
- rst pulsed during WSETUP of a write of 0xFF to addr 7 (previously 0x00):
  - ram_write_enable never rises; no ack.
  - A later read of addr 7 returns 0x00.
  - All outputs return to reset values.
- Requester 1 holds req through its ack cycle with a read of addr 0:
  - A second transaction is granted in the next IDLE cycle.
  - Two acks are separated by exactly 3 cycles.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of the 16x8 scratch RAM.
// Reads are registered back per requester; writes use a setup/strobe/hold sequence.
module ram_arbiter #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req,
  input  logic [1:0]      we,
  input  logic [2*AW-1:0] addr,
  input  logic [2*DW-1:0] wdata,
  output logic [1:0]      ack,
  output logic [2*DW-1:0] rdata,
  output logic            busy,
  output logic            owner,
  output logic [AW-1:0]   ram_addr_read,
  output logic            ram_read_enable,
  input  logic [DW-1:0]   ram_data_out,
  output logic [DW-1:0]   ram_data_in,
  output logic [AW-1:0]   ram_addr_write,
  output logic            ram_write_enable
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD      = 3'd1;
  localparam logic [2:0] WSETUP  = 3'd2;
  localparam logic [2:0] WSTROBE = 3'd3;
  localparam logic [2:0] WHOLD   = 3'd4;
  localparam logic [2:0] ACK     = 3'd5;

  logic [2:0]      r_state;
  logic [2:0]      w_next;
  logic            r_last_grant;
  logic            r_owner;
  logic [1:0]      r_ack;
  logic            r_busy;
  logic            r_rd_en;
  logic            r_wr_en;
  logic [2*DW-1:0] r_rdata;
  logic [AW-1:0]   r_addr_rd;
  logic [AW-1:0]   r_addr_wr;
  logic [DW-1:0]   r_wdata;

  logic            w_grant;
  logic            w_gnt_idx;
  logic            w_gnt_we;
  logic [AW-1:0]   w_gnt_addr;
  logic [DW-1:0]   w_gnt_wdata;

  // Winner selection: on contention the requester that did not win last time.
  always_comb begin
    w_grant   = |req;
    w_gnt_idx = req[1];
    if (req == 2'b11) begin
      w_gnt_idx = ~r_last_grant;
    end
    w_gnt_we    = w_gnt_idx ? we[1] : we[0];
    w_gnt_addr  = w_gnt_idx ? addr[2*AW-1:AW] : addr[AW-1:0];
    w_gnt_wdata = w_gnt_idx ? wdata[2*DW-1:DW] : wdata[DW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_next = w_gnt_we ? WSETUP : RD;
      RD:      w_next = ACK;
      WSETUP:  w_next = WSTROBE;
      WSTROBE: w_next = WHOLD;
      WHOLD:   w_next = ACK;
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Status and strobe flops follow the next state so each output is a single clean flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack   <= 2'b00;
      r_busy  <= 1'b0;
      r_rd_en <= 1'b0;
      r_wr_en <= 1'b0;
    end else begin
      r_busy  <= (w_next != IDLE);
      r_rd_en <= (w_next == RD);
      r_wr_en <= (w_next == WSTROBE);
      r_ack   <= (w_next == ACK) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
    end
  end

  // Transaction latch at grant, read-data capture at the end of RD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_addr_rd    <= '0;
      r_addr_wr    <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
    end else begin
      if (r_state == IDLE && w_grant) begin
        r_owner      <= w_gnt_idx;
        r_last_grant <= w_gnt_idx;
        r_addr_rd    <= w_gnt_addr;
        r_addr_wr    <= w_gnt_addr;
        r_wdata      <= w_gnt_wdata;
      end
      if (r_state == RD) begin
        if (r_owner) begin
          r_rdata[2*DW-1:DW] <= ram_data_out;
        end else begin
          r_rdata[DW-1:0] <= ram_data_out;
        end
      end
    end
  end

  assign ack              = r_ack;
  assign rdata            = r_rdata;
  assign busy             = r_busy;
  assign owner            = r_owner;
  assign ram_addr_read    = r_addr_rd;
  assign ram_read_enable  = r_rd_en;
  assign ram_data_in      = r_wdata;
  assign ram_addr_write   = r_addr_wr;
  assign ram_write_enable = r_wr_en;

endmodule
